// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the RISC231 writeback path.
// Also holds the read-bypass selection used by the write arbiter.
package rf_pkg;

    localparam int unsigned Nreg  = 32;
    localparam int unsigned Dbits = 32;
    localparam int unsigned Abits = $clog2(Nreg);

    typedef struct packed {
        logic [Abits-1:0] addr;
        logic [Dbits-1:0] data;
    } rf_write_t;

    // Register 0 is hard-wired to zero; an in-flight write overrides stale array data.
    function automatic logic [Dbits-1:0] bypass_read(
        input logic [Abits-1:0] raddr,
        input logic [Dbits-1:0] rdata,
        input logic             wr,
        input logic [Abits-1:0] waddr,
        input logic [Dbits-1:0] wdata
    );
        logic [Dbits-1:0] result;
        result = rdata;
        if (raddr == '0) begin
            result = '0;
        end else if (wr && (raddr == waddr)) begin
            result = wdata;
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback-request, register-file write and read-bypass signals of the write arbiter.
// The slave modport is the arbiter; the master modport is the surrounding pipeline.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned Nreq = 2
) ();

    logic                       stall;
    logic [Nreq-1:0]            req_valid;
    logic [Nreq-1:0][Abits-1:0] req_addr;
    logic [Nreq-1:0][Dbits-1:0] req_data;
    logic [Nreq-1:0]            req_ready;

    logic                       wr;
    logic [Abits-1:0]           WriteAddr;
    logic [Dbits-1:0]           WriteData;

    logic [Abits-1:0]           ReadAddr1;
    logic [Abits-1:0]           ReadAddr2;
    logic [Dbits-1:0]           ReadData1;
    logic [Dbits-1:0]           ReadData2;
    logic [Dbits-1:0]           FwdData1;
    logic [Dbits-1:0]           FwdData2;

    modport slave (
        input  stall,
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready,
        output wr,
        output WriteAddr,
        output WriteData,
        input  ReadAddr1,
        input  ReadAddr2,
        input  ReadData1,
        input  ReadData2,
        output FwdData1,
        output FwdData2
    );

    modport master (
        output stall,
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready,
        input  wr,
        input  WriteAddr,
        input  WriteData,
        output ReadAddr1,
        output ReadAddr2,
        output ReadData1,
        output ReadData2,
        input  FwdData1,
        input  FwdData2
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans req from ptr upward, wrapping modulo Nreq,
// and grants the first set bit as a one-hot gnt plus its encoded index.
module rr_arbiter #(
    parameter int unsigned Nreq    = 2,
    parameter int unsigned IdxBits = $clog2(Nreq)
) (
    input  logic [Nreq-1:0]    req,
    input  logic [IdxBits-1:0] ptr,
    output logic [Nreq-1:0]    gnt,
    output logic [IdxBits-1:0] idx
);

    logic        found;
    int unsigned pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < Nreq; k++) begin
            pos = (32'(ptr) + k) % Nreq;
            if (!found && req[pos[IdxBits-1:0]]) begin
                gnt[pos[IdxBits-1:0]] = 1'b1;
                idx                   = pos[IdxBits-1:0];
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin share of the register-file write port among Nreq writeback sources,
// with a registered write stage and combinational read bypass of the in-flight write.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned Nreq = 2
) (
    input  logic                clock,
    input  logic                reset,
    rf_write_arbiter_if.slave   bus
);

    localparam int unsigned IdxBits = $clog2(Nreq);

    logic [Nreq-1:0]    gnt;
    logic [IdxBits-1:0] win_idx;
    logic               handshake;
    rf_write_t          winner;

    logic [IdxBits-1:0] ptr_q, ptr_d;
    logic               wr_q, wr_d;
    rf_write_t          wb_q, wb_d;

    rr_arbiter #(
        .Nreq    (Nreq),
        .IdxBits (IdxBits)
    ) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win_idx)
    );

    // gnt is already qualified by req_valid, so ready never rises without valid.
    assign bus.req_ready = (reset || bus.stall) ? '0 : gnt;
    assign handshake     = |bus.req_ready;

    always_comb begin
        winner.addr = bus.req_addr[win_idx];
        winner.data = bus.req_data[win_idx];
    end

    always_comb begin
        ptr_d = ptr_q;
        wr_d  = 1'b0;
        wb_d  = wb_q;
        if (handshake) begin
            // Writes to register 0 complete the handshake but never reach the array.
            wr_d  = (winner.addr != '0);
            wb_d  = winner;
            ptr_d = (32'(win_idx) == Nreq - 1) ? '0 : win_idx + IdxBits'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            wr_q  <= 1'b0;
            wb_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            wr_q  <= wr_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.wr        = wr_q;
    assign bus.WriteAddr = wb_q.addr;
    assign bus.WriteData = wb_q.data;

    assign bus.FwdData1 = bypass_read(bus.ReadAddr1, bus.ReadData1, wr_q, wb_q.addr, wb_q.data);
    assign bus.FwdData2 = bypass_read(bus.ReadAddr2, bus.ReadData2, wr_q, wb_q.addr, wb_q.data);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: vector table with a write scoreboard,
// plus a hand-driven asynchronous-reset sequence.
module tb_rf_write_arbiter;

    localparam int unsigned NREQ = 2;

    typedef struct {
        logic        stall;
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_item_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rf_write_arbiter_if #(.Nreq(NREQ)) bus ();

    rf_write_arbiter #(.Nreq(NREQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Environment register file; reg 0 holds junk so the forced-zero read is visible.
    logic [31:0] env_rf [32];
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) env_rf[k] <= (k == 0) ? 32'hFFFF_FFFF : 32'h0;
        end else if (bus.wr) begin
            env_rf[bus.WriteAddr] <= bus.WriteData;
        end
    end
    assign bus.ReadData1 = env_rf[bus.ReadAddr1];
    assign bus.ReadData2 = env_rf[bus.ReadAddr2];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_rf [32];
    wr_item_t    sb_q [$];
    vec_t        vecs [15];
    logic [4:0]  held_addr;
    logic [31:0] held_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_fwd(input logic [4:0] ra, input wr_item_t it);
        if (ra == 5'd0) return 32'h0;
        if (it.wr && ra == it.addr) return it.data;
        return model_rf[ra];
    endfunction

    task automatic drive(input vec_t v);
        bus.stall       = v.stall;
        bus.req_valid   = v.valid;
        bus.req_addr[0] = v.a0;
        bus.req_data[0] = v.d0;
        bus.req_addr[1] = v.a1;
        bus.req_data[1] = v.d1;
        bus.ReadAddr1   = v.ra1;
        bus.ReadAddr2   = v.ra2;
    endtask

    initial begin
        wr_item_t it;
        wr_item_t nx;
        for (int k = 0; k < 32; k++) model_rf[k] = 32'h0;
        held_addr = '0;
        held_data = '0;

        //            stall valid a0     d0            a1     d1            ra1    ra2    ready
        vecs[0]  = '{1'b0, 2'b10, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 5'd3,  5'd4,  2'b10};
        vecs[1]  = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  5'd6,  2'b00};
        vecs[2]  = '{1'b0, 2'b11, 5'd1,  32'h101,      5'd11, 32'h111,      5'd7,  5'd8,  2'b01};
        vecs[3]  = '{1'b0, 2'b11, 5'd2,  32'h202,      5'd11, 32'h111,      5'd5,  5'd1,  2'b10};
        vecs[4]  = '{1'b0, 2'b11, 5'd2,  32'h202,      5'd12, 32'h212,      5'd11, 5'd1,  2'b01};
        vecs[5]  = '{1'b0, 2'b11, 5'd3,  32'h303,      5'd12, 32'h212,      5'd2,  5'd11, 2'b10};
        vecs[6]  = '{1'b0, 2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        5'd12, 5'd2,  2'b01};
        vecs[7]  = '{1'b0, 2'b11, 5'd3,  32'h303,      5'd13, 32'h313,      5'd0,  5'd12, 2'b10};
        vecs[8]  = '{1'b1, 2'b11, 5'd3,  32'h303,      5'd14, 32'h314,      5'd13, 5'd0,  2'b00};
        vecs[9]  = '{1'b1, 2'b11, 5'd3,  32'h303,      5'd14, 32'h314,      5'd13, 5'd3,  2'b00};
        vecs[10] = '{1'b1, 2'b11, 5'd3,  32'h303,      5'd14, 32'h314,      5'd3,  5'd13, 2'b00};
        vecs[11] = '{1'b0, 2'b11, 5'd3,  32'h303,      5'd14, 32'h314,      5'd13, 5'd3,  2'b01};
        vecs[12] = '{1'b0, 2'b10, 5'd4,  32'h404,      5'd7,  32'hA5A5A5A5, 5'd3,  5'd14, 2'b10};
        vecs[13] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd7,  2'b00};
        vecs[14] = '{1'b0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd7,  5'd5,  2'b00};

        // Reset state, with both requesters valid to show ready is suppressed.
        drive('{1'b0, 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, 5'd0, 2'b00});
        #7;
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_wr", 32'(bus.wr), 32'h0);
        check("reset_WriteAddr", 32'(bus.WriteAddr), 32'h0);
        check("reset_WriteData", bus.WriteData, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        sb_q.push_back('{1'b0, 5'd0, 32'h0});

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            @(negedge clock);
            it = sb_q.pop_front();
            check($sformatf("v%0d_wr", i), 32'(bus.wr), 32'(it.wr));
            check($sformatf("v%0d_WriteAddr", i), 32'(bus.WriteAddr), 32'(it.addr));
            check($sformatf("v%0d_WriteData", i), bus.WriteData, it.data);
            check($sformatf("v%0d_FwdData1", i), bus.FwdData1, exp_fwd(vecs[i].ra1, it));
            check($sformatf("v%0d_FwdData2", i), bus.FwdData2, exp_fwd(vecs[i].ra2, it));
            if (it.wr) model_rf[it.addr] = it.data;
            check($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
            nx = '{1'b0, held_addr, held_data};
            if (vecs[i].exp_ready != 2'b00) begin
                held_addr = vecs[i].exp_ready[1] ? vecs[i].a1 : vecs[i].a0;
                held_data = vecs[i].exp_ready[1] ? vecs[i].d1 : vecs[i].d0;
                nx = '{(held_addr != 5'd0), held_addr, held_data};
            end
            sb_q.push_back(nx);
            @(posedge clock); #1;
        end

        // Drain the last scoreboard entry.
        @(negedge clock);
        it = sb_q.pop_front();
        check("drain_wr", 32'(bus.wr), 32'(it.wr));
        check("drain_WriteAddr", 32'(bus.WriteAddr), 32'(it.addr));

        // Asynchronous reset while a write is on the output, with rr_ptr advanced to 1.
        @(posedge clock); #1;
        drive('{1'b0, 2'b01, 5'd9, 32'h99, 5'd10, 32'hAA, 5'd0, 5'd0, 2'b00});
        @(negedge clock);
        check("arst_pre_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        check("arst_pre_wr", 32'(bus.wr), 32'h1);
        check("arst_pre_WriteAddr", 32'(bus.WriteAddr), 32'd9);
        #2;
        reset = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        check("arst_wr", 32'(bus.wr), 32'h0);
        check("arst_WriteAddr", 32'(bus.WriteAddr), 32'h0);
        check("arst_WriteData", bus.WriteData, 32'h0);
        check("arst_req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_reset_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clock); #1;
        bus.req_valid = 2'b00;
        check("post_reset_wr", 32'(bus.wr), 32'h1);
        check("post_reset_WriteAddr", 32'(bus.WriteAddr), 32'd9);
        check("post_reset_WriteData", bus.WriteData, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the RISC231 register file between several writeback sources (ALU, load unit, multiplier, …) using a round-robin arbiter with a valid/ready handshake. The block registers the winning write and drives it onto the register file's `wr`/`WriteAddr`/`WriteData` one cycle later. It also supplies a bypass path so that reads issued while a write is in flight return the new value. It sits between the writeback stage and the register file.

## Interface
- `Nreg`, 32: number of architectural registers; `Abits = $clog2(Nreg)`.
- `Dbits`, 32: data width.
- `Nreq`, 2: number of write requesters (2..8).
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `stall` in 1: when 1, no new request is granted.
- `req_valid` in [Nreq]: requester i holds a write.
- `req_addr` in [Nreq][Abits]: destination register of requester i.
- `req_data` in [Nreq][Dbits]: write data of requester i.
- `req_ready` out [Nreq]: grant; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `wr` out 1: register-file write enable (registered).
- `WriteAddr` out [Abits]: register-file write address (registered).
- `WriteData` out [Dbits]: register-file write data (registered).
- `ReadAddr1`, `ReadAddr2` in [Abits]: the read addresses currently driven to the register file.
- `ReadData1`, `ReadData2` in [Dbits]: raw register-file read data.
- `FwdData1`, `FwdData2` out [Dbits]: read data after bypass; combinational.

## Operation
- **Reset values:** `wr`=0, `WriteAddr`=0, `WriteData`=0, round-robin pointer `rr_ptr`=0. `req_ready` is all 0 while `reset`=1.
- **Arbitration (combinational):**
  - When `stall`=0, scan `req_valid` starting at index `rr_ptr`, wrapping modulo `Nreq`.
  - The first valid index i receives `req_ready[i]`=1; all other bits are 0.
  - At most one grant is issued per cycle.
- **`req_ready` is a pure grant:** a requester may not wait for ready before asserting valid. `req_ready` depends on `req_valid`, so it can be 1 only when `req_valid` is 1.
- **On a handshake from requester i:**
  - Next cycle: `wr`=(`req_addr[i]`≠0), `WriteAddr`=`req_addr[i]`, `WriteData`=`req_data[i]`.
  - `rr_ptr` becomes (i+1) mod `Nreq`.
- **No handshake** (nothing valid, or `stall`=1): next cycle `wr`=0. `WriteAddr`/`WriteData` hold their values and `rr_ptr` holds.
- **Register 0:** a write to register 0 is accepted (handshake completes, `rr_ptr` advances) but is dropped, so `wr` stays 0.
- **Bypass:**
  - `FwdDataK` = `WriteData` when `wr`=1 and `ReadAddrK`==`WriteAddr`; otherwise `ReadDataK`.
  - `ReadAddrK`=0 always yields 0.
- **State machine:** none beyond `rr_ptr` and the output register. The output stage never back-pressures; it accepts one write every cycle.

## Timing
- **Latency:** handshake in cycle N → `wr`=1 during N+1 → register file updated at the rising edge that ends N+1.
- **Throughput:** one write per cycle.
- **Fairness:** with all `Nreq` requesters continuously valid, each is granted exactly once every `Nreq` cycles.
- **Stall:**
  - A write already on the output (`wr`=1) completes normally.
  - Asserting `stall` in cycle N gives `req_ready`=0 in N and `wr`=0 in N+1.
- **Simultaneous events:** a request to register R in cycle N while a read of R occurs in N+1 is resolved by the bypass. Two requesters targeting the same register in consecutive cycles are written in grant order; the last grant wins.
- **Reset mid-operation:** an in-flight write is discarded (`wr` drops immediately). A requester whose handshake was lost must re-request after reset.

## Structure
- **Package `rf_pkg`:** `Nreg`/`Dbits` defaults, the `Abits` constant, and the `rf_write_t` struct {addr, data}, shared with `register_file` instantiations and the writeback stage.
- **Sub-module `rr_arbiter`:** parameterized by `Nreq`; inputs `req` and `ptr`, outputs one-hot `gnt` and the encoded index. Pure combinational.
- **`rf_write_arbiter` itself:** instantiates `rr_arbiter` and contains the pointer register, the output register and the bypass muxes.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with `wr`=1 → `wr`, `WriteAddr`, `WriteData` go to 0 without waiting for a clock edge; after release, the first grant goes to index 0.
- **Single write:** requester 1 writes reg 5 = 0xDEADBEEF, no contention → `req_ready[1]`=1 that cycle; next cycle `wr`=1, `WriteAddr`=5, `WriteData`=0xDEADBEEF; a later read of reg 5 returns 0xDEADBEEF.
- **Contention:** both requesters valid for 4 cycles (req0 → regs 1..4, req1 → regs 11..14) → grant order 0,1,0,1; `WriteAddr` sequence 1,11,2,12.
- **Register 0:** requester 0 writes reg 0 = 0x1234 → handshake completes and `rr_ptr` advances, `wr` stays 0; `FwdData1` with `ReadAddr1`=0 returns 0.
- **Bypass:** write reg 7 = 0xA5A5A5A5 with `ReadAddr2`=7 during the `wr` cycle, where the register file still returns the old value 0 → `FwdData2`=0xA5A5A5A5.
- **Stall:** `stall`=1 for 3 cycles with both requesters valid → `req_ready`=0 and `wr`=0 from the second stalled cycle; on release, the grant resumes at the saved `rr_ptr`.
